fpu_cpx_outq: RTL and testbench
===============================

Name: fpu_cpx_outq

Overview:
- Output queue directly downstream of the FPU output arbiter.
- On each cycle where the arbiter registers a winning pipe (dest_rdy one-hot), captures that pipe's result data, exception flags, request ID and thread into a small FIFO.
- Presents the FIFO head to the CPX as a valid/grant packet interface.
- Raises an almost-full indication so upstream issue can throttle before overflow.

Parameters:
DEPTH, 4, number of packet entries (power of 2, >=2)
DATA_W, 64, result data width per pipe
AFULL_LVL, 2, occupancy at or above which outq_afull asserts

Ports:
rclk  in  1  global clock
reset  in  1  synchronous reset, active high
dest_rdy  in  3  registered winner {div,mul,add}; at most one bit set
req_thread  in  2  thread ID of the winning request
fp_cpx_req_cq  in  8  request ID of the winning request
add_out_data  in  DATA_W  add pipe result, valid when dest_rdy[0]
mul_out_data  in  DATA_W  mul pipe result, valid when dest_rdy[1]
div_out_data  in  DATA_W  div pipe result, valid when dest_rdy[2]
add_out_exc  in  5  add pipe IEEE exception flags
mul_out_exc  in  5  mul pipe IEEE exception flags
div_out_exc  in  5  div pipe IEEE exception flags
cpx_fpu_gnt  in  1  CPX accepts the head packet this cycle
fpu_cpx_vld  out  1  head packet valid
fpu_cpx_pkt  out  DATA_W+17  {thread[1:0], req_id[7:0], pipe[1:0], exc[4:0], data}
outq_afull  out  1  occupancy >= AFULL_LVL
outq_err  out  2  sticky {multi_hot, overflow}

Behaviour:
- Clocking and reset: one clock, rclk. reset is synchronous and active-high.
- Reset values: count=0, rd/wr pointers=0, fpu_cpx_vld=0, fpu_cpx_pkt=0, outq_afull=0, outq_err=0.
- Reset mid-operation discards all entries. Inputs in the reset cycle are ignored.
- Push condition: dest_rdy is exactly one-hot.
- Packet captured on a push:
  - data and exc from the selected pipe.
  - pipe encoding: add=2'b01, mul=2'b10, div=2'b11.
  - thread = req_thread; req_id = fp_cpx_req_cq.
- dest_rdy=000: no push. This is the normal case.
- dest_rdy multi-hot:
  - no push.
  - outq_err[1] sets and holds until reset.
- Pop condition: fpu_cpx_vld && cpx_fpu_gnt.
- Head register:
  - fpu_cpx_pkt is registered.
  - A push into an empty queue appears on fpu_cpx_vld/fpu_cpx_pkt in the next cycle (latency 1).
  - fpu_cpx_pkt is stable while fpu_cpx_vld=1 and cpx_fpu_gnt=0.
- After a pop:
  - the next entry is presented the following cycle, so back-to-back grants drain one entry per cycle.
  - if the queue becomes empty, fpu_cpx_vld drops the cycle after the pop.
- Simultaneous push and pop:
  - count is unchanged.
  - allowed even when count==DEPTH; the pop frees the slot in the same cycle.
- Push when count==DEPTH with no pop:
  - packet dropped, count unchanged.
  - outq_err[0] sets, sticky until reset.
- Empty queue with cpx_fpu_gnt=1 is ignored; nothing pops.
- Ordering is strict FIFO across all pipes and threads; no reordering.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- outq_afull is registered: equals (next count >= AFULL_LVL), so it is asserted in the same cycle the count reaches the level.
- FSM (derived from count): EMPTY (count=0), ACTIVE (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY->ACTIVE on push.
  - ACTIVE->FULL on push without pop.
  - FULL->ACTIVE on pop without push.
  - ACTIVE->EMPTY on pop without push when count=1.

Test Plan:
- Single push: after reset, dest_rdy=001, req_thread=2, req_id=0x5A, add_out_data=0x3FF0000000000000, exc=0 -> next cycle fpu_cpx_vld=1 with pkt fields thread=2, id=0x5A, pipe=01, data=0x3FF0000000000000. gnt=1 -> vld=0 the cycle after.
- Fill/stall: gnt held 0, four pushes (div, mul, add, div) -> count=4, outq_afull=1 from the 2nd push. A 5th push sets outq_err=2'b01, and the head remains the first div packet. Then gnt=1 for 4 cycles -> packets emerge in push order with pipe=11,10,01,11.
- Full push+pop: at count=4, push mul and grant in the same cycle -> no overflow, count stays 4, the mul packet is last out.
- Multi-hot: dest_rdy=110 -> no push, outq_err=2'b10, vld remains 0.
- Pointer wrap: 10 push/pop pairs with DEPTH=4, using distinct req_id 0..9 -> req_ids emerge 0..9 in order.
- Mid-operation reset: reset asserted at count=3 -> next cycle vld=0, afull=0, err=0. A push in the following cycle appears normally.

Source files
------------

// File: rtl/fpu_cpx_outq.sv
// rtl/fpu_cpx_outq.sv - FPU result queue feeding the CPX valid/grant packet interface
module fpu_cpx_outq #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 64,
    parameter int AFULL_LVL = 2
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic [2:0]        dest_rdy,
    input  logic [1:0]        req_thread,
    input  logic [7:0]        fp_cpx_req_cq,
    input  logic [DATA_W-1:0] add_out_data,
    input  logic [DATA_W-1:0] mul_out_data,
    input  logic [DATA_W-1:0] div_out_data,
    input  logic [4:0]        add_out_exc,
    input  logic [4:0]        mul_out_exc,
    input  logic [4:0]        div_out_exc,
    input  logic              cpx_fpu_gnt,
    output logic              fpu_cpx_vld,
    output logic [DATA_W+16:0] fpu_cpx_pkt,
    output logic              outq_afull,
    output logic [1:0]        outq_err
);
    localparam int PW = DATA_W + 17;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [PW-1:0]   mem [DEPTH];
    logic [PW-1:0]   push_pkt;
    logic [PW-1:0]   head_nxt;
    logic            multi_hot;
    logic            one_hot;
    logic            pop;
    logic            push;
    logic            overflow;

    always_comb begin
        multi_hot = (dest_rdy & (dest_rdy - 3'd1)) != 3'd0;
        one_hot   = (dest_rdy != 3'd0) && !multi_hot;
        pop       = fpu_cpx_vld && cpx_fpu_gnt;
        // A pop in the same cycle frees the slot, so a full queue still accepts the push.
        push      = one_hot && ((state != FULL) || pop);
        overflow  = one_hot && (state == FULL) && !pop;

        case (dest_rdy)
            3'b010:  push_pkt = {req_thread, fp_cpx_req_cq, 2'b10, mul_out_exc, mul_out_data};
            3'b100:  push_pkt = {req_thread, fp_cpx_req_cq, 2'b11, div_out_exc, div_out_data};
            default: push_pkt = {req_thread, fp_cpx_req_cq, 2'b01, add_out_exc, add_out_data};
        endcase

        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count + CW'(push) - CW'(pop);
        // Bypass the array when the new entry becomes the head in the same edge it is written.
        head_nxt   = (push && (count == CW'(pop))) ? push_pkt : mem[rd_ptr_nxt];
    end

    always_ff @(posedge rclk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state       <= EMPTY;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fpu_cpx_vld <= 1'b0;
            fpu_cpx_pkt <= '0;
            outq_afull  <= 1'b0;
            outq_err    <= 2'b00;
        end else begin
            count       <= count_nxt;
            rd_ptr      <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            fpu_cpx_vld <= (count_nxt != '0);
            if (count_nxt != '0) begin
                fpu_cpx_pkt <= head_nxt;
            end
            outq_afull  <= (count_nxt >= CW'(AFULL_LVL));
            outq_err    <= outq_err | {multi_hot, overflow};
            case (state)
                EMPTY:   if (push) state <= ACTIVE;
                ACTIVE:  if (count_nxt == CW'(DEPTH)) state <= FULL;
                         else if (count_nxt == '0) state <= EMPTY;
                FULL:    if (pop && !push) state <= ACTIVE;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_cpx_outq.sv
// tb/tb_fpu_cpx_outq.sv - self-checking bench for fpu_cpx_outq against a queue model
module tb_fpu_cpx_outq;
    localparam int DEPTH     = 4;
    localparam int DATA_W    = 64;
    localparam int AFULL_LVL = 2;
    localparam int PW        = DATA_W + 17;

    logic              rclk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        dest_rdy = '0;
    logic [1:0]        req_thread = '0;
    logic [7:0]        fp_cpx_req_cq = '0;
    logic [DATA_W-1:0] add_out_data = '0;
    logic [DATA_W-1:0] mul_out_data = '0;
    logic [DATA_W-1:0] div_out_data = '0;
    logic [4:0]        add_out_exc = '0;
    logic [4:0]        mul_out_exc = '0;
    logic [4:0]        div_out_exc = '0;
    logic              cpx_fpu_gnt = 1'b0;
    logic              fpu_cpx_vld;
    logic [PW-1:0]     fpu_cpx_pkt;
    logic              outq_afull;
    logic [1:0]        outq_err;

    fpu_cpx_outq #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AFULL_LVL(AFULL_LVL)) dut (
        .rclk(rclk), .reset(reset), .dest_rdy(dest_rdy), .req_thread(req_thread),
        .fp_cpx_req_cq(fp_cpx_req_cq), .add_out_data(add_out_data),
        .mul_out_data(mul_out_data), .div_out_data(div_out_data),
        .add_out_exc(add_out_exc), .mul_out_exc(mul_out_exc), .div_out_exc(div_out_exc),
        .cpx_fpu_gnt(cpx_fpu_gnt), .fpu_cpx_vld(fpu_cpx_vld), .fpu_cpx_pkt(fpu_cpx_pkt),
        .outq_afull(outq_afull), .outq_err(outq_err)
    );

    always #5 rclk = ~rclk;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [PW-1:0] mq[$];
    logic [1:0]    merr = 2'b00;

    wire [7:0] pkt_id   = fpu_cpx_pkt[DATA_W+14:DATA_W+7];
    wire [1:0] pkt_pipe = fpu_cpx_pkt[DATA_W+6:DATA_W+5];

    task automatic drive(input logic [2:0] dr, input logic [1:0] th, input logic [7:0] id,
                         input logic [63:0] d, input logic [4:0] e, input logic g);
        dest_rdy      = dr;
        req_thread    = th;
        fp_cpx_req_cq = id;
        add_out_data  = {$urandom, $urandom};
        mul_out_data  = {$urandom, $urandom};
        div_out_data  = {$urandom, $urandom};
        add_out_exc   = 5'($urandom);
        mul_out_exc   = 5'($urandom);
        div_out_exc   = 5'($urandom);
        if (dr[0]) begin add_out_data = d; add_out_exc = e; end
        if (dr[1]) begin mul_out_data = d; mul_out_exc = e; end
        if (dr[2]) begin div_out_data = d; div_out_exc = e; end
        cpx_fpu_gnt = g;
    endtask

    // One clock: the model applies pop-then-push as the queue sees it at the edge.
    task automatic tick();
        logic [PW-1:0] p;
        logic          has;
        logic [PW-1:0] dummy;
        @(posedge rclk);
        if (reset) begin
            mq.delete();
            merr = 2'b00;
        end else begin
            if (cpx_fpu_gnt && mq.size() > 0) dummy = mq.pop_front();
            has = 1'b1;
            p   = '0;
            case (dest_rdy)
                3'b000: has = 1'b0;
                3'b001: p = {req_thread, fp_cpx_req_cq, 2'b01, add_out_exc, add_out_data};
                3'b010: p = {req_thread, fp_cpx_req_cq, 2'b10, mul_out_exc, mul_out_data};
                3'b100: p = {req_thread, fp_cpx_req_cq, 2'b11, div_out_exc, div_out_data};
                default: begin has = 1'b0; merr[1] = 1'b1; end
            endcase
            if (has) begin
                if (mq.size() < DEPTH) mq.push_back(p);
                else merr[0] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'b000, 2'd0, 8'd0, 64'd0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (fpu_cpx_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", fpu_cpx_vld); end
        n_vec++; if (fpu_cpx_pkt !== '0) begin n_bad++; $display("FAIL reset_pkt got %h want 0", fpu_cpx_pkt); end
        n_vec++; if (outq_afull !== 1'b0) begin n_bad++; $display("FAIL reset_afull got %b want 0", outq_afull); end
        n_vec++; if (outq_err !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", outq_err); end
    endtask

    task automatic test_single_push();
        logic [PW-1:0] exp_pkt;
        exp_pkt = {2'd2, 8'h5A, 2'b01, 5'd0, 64'h3FF0000000000000};
        do_reset();
        drive(3'b001, 2'd2, 8'h5A, 64'h3FF0000000000000, 5'd0, 1'b0);
        tick();
        n_vec++; if (fpu_cpx_vld !== 1'b1) begin n_bad++; $display("FAIL single_vld got %b want 1", fpu_cpx_vld); end
        n_vec++; if (fpu_cpx_pkt !== exp_pkt) begin n_bad++; $display("FAIL single_pkt got %h want %h", fpu_cpx_pkt, exp_pkt); end
        drive(3'b000, 2'd0, 8'd0, 64'd0, 5'd0, 1'b1);
        tick();
        n_vec++; if (fpu_cpx_vld !== 1'b0) begin n_bad++; $display("FAIL single_drain_vld got %b want 0", fpu_cpx_vld); end
    endtask

    task automatic test_fill_stall();
        logic [2:0] dr_seq [4];
        logic [1:0] pipe_seq [4];
        dr_seq   = '{3'b100, 3'b010, 3'b001, 3'b100};
        pipe_seq = '{2'b11, 2'b10, 2'b01, 2'b11};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(dr_seq[i], 2'(i), 8'(i + 1), {$urandom, $urandom}, 5'($urandom), 1'b0);
            tick();
            n_vec++; if (outq_afull !== (i >= 1)) begin n_bad++; $display("FAIL fill_afull[%0d] got %b want %b", i, outq_afull, (i >= 1)); end
        end
        drive(3'b100, 2'd0, 8'd5, 64'd0, 5'd0, 1'b0);
        tick();
        n_vec++; if (outq_err !== 2'b01) begin n_bad++; $display("FAIL overflow_err got %b want 01", outq_err); end
        n_vec++; if (pkt_id !== 8'd1 || pkt_pipe !== 2'b11) begin n_bad++; $display("FAIL overflow_head got id %h pipe %b want id 01 pipe 11", pkt_id, pkt_pipe); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (fpu_cpx_vld !== 1'b1 || pkt_pipe !== pipe_seq[i] || pkt_id !== 8'(i + 1)) begin
                n_bad++; $display("FAIL drain_order[%0d] got vld %b pipe %b id %h want 1 %b %h", i, fpu_cpx_vld, pkt_pipe, pkt_id, pipe_seq[i], 8'(i + 1));
            end
            drive(3'b000, 2'd0, 8'd0, 64'd0, 5'd0, 1'b1);
            tick();
        end
        n_vec++; if (fpu_cpx_vld !== 1'b0) begin n_bad++; $display("FAIL drain_empty_vld got %b want 0", fpu_cpx_vld); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(3'b001, 2'd1, 8'(8'h10 + i), {$urandom, $urandom}, 5'd0, 1'b0);
            tick();
        end
        drive(3'b010, 2'd3, 8'h14, 64'h1234, 5'h1F, 1'b1);
        tick();
        n_vec++; if (outq_err !== 2'b00) begin n_bad++; $display("FAIL fullpp_err got %b want 00", outq_err); end
        n_vec++; if (outq_afull !== 1'b1) begin n_bad++; $display("FAIL fullpp_afull got %b want 1", outq_afull); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (fpu_cpx_vld !== 1'b1 || pkt_id !== 8'(8'h11 + i)) begin
                n_bad++; $display("FAIL fullpp_order[%0d] got vld %b id %h want 1 %h", i, fpu_cpx_vld, pkt_id, 8'(8'h11 + i));
            end
            if (i == 3) begin
                n_vec++; if (pkt_pipe !== 2'b10) begin n_bad++; $display("FAIL fullpp_last_pipe got %b want 10", pkt_pipe); end
            end
            drive(3'b000, 2'd0, 8'd0, 64'd0, 5'd0, 1'b1);
            tick();
        end
        n_vec++; if (fpu_cpx_vld !== 1'b0) begin n_bad++; $display("FAIL fullpp_empty got %b want 0", fpu_cpx_vld); end
    endtask

    task automatic test_multi_hot();
        do_reset();
        drive(3'b110, 2'd0, 8'h33, 64'd7, 5'd0, 1'b0);
        tick();
        n_vec++; if (outq_err !== 2'b10) begin n_bad++; $display("FAIL multihot_err got %b want 10", outq_err); end
        n_vec++; if (fpu_cpx_vld !== 1'b0) begin n_bad++; $display("FAIL multihot_vld got %b want 0", fpu_cpx_vld); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(3'b010, 2'd0, 8'd0, {$urandom, $urandom}, 5'd0, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            n_vec++; if (pkt_id !== 8'(i - 1)) begin n_bad++; $display("FAIL wrap_id[%0d] got %h want %h", i - 1, pkt_id, 8'(i - 1)); end
            drive(3'b001 << (i % 3), 2'(i), 8'(i), {$urandom, $urandom}, 5'($urandom), 1'b1);
            tick();
        end
        n_vec++; if (pkt_id !== 8'd9) begin n_bad++; $display("FAIL wrap_id[9] got %h want 09", pkt_id); end
        drive(3'b000, 2'd0, 8'd0, 64'd0, 5'd0, 1'b1);
        tick();
        n_vec++; if (fpu_cpx_vld !== 1'b0) begin n_bad++; $display("FAIL wrap_empty got %b want 0", fpu_cpx_vld); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(3'b011, 2'd0, 8'd0, 64'd0, 5'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 2'd0, 8'(i), {$urandom, $urandom}, 5'd0, 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(3'b001, 2'd1, 8'h99, 64'd1, 5'd0, 1'b1);
        tick();
        reset = 1'b0;
        n_vec++; if (fpu_cpx_vld !== 1'b0 || outq_afull !== 1'b0 || outq_err !== 2'b00) begin
            n_bad++; $display("FAIL midreset_state got vld %b afull %b err %b want 0 0 00", fpu_cpx_vld, outq_afull, outq_err);
        end
        drive(3'b001, 2'd3, 8'h77, 64'hABCD, 5'h2, 1'b0);
        tick();
        n_vec++; if (fpu_cpx_vld !== 1'b1 || fpu_cpx_pkt !== {2'd3, 8'h77, 2'b01, 5'h2, 64'hABCD}) begin
            n_bad++; $display("FAIL midreset_push got vld %b pkt %h", fpu_cpx_vld, fpu_cpx_pkt);
        end
    endtask

    task automatic test_random();
        logic [2:0] dr;
        int         r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      dr = 3'b000;
            else if (r < 98) dr = 3'b001 << $urandom_range(0, 2);
            else             dr = 3'b111;
            drive(dr, 2'($urandom), 8'($urandom), {$urandom, $urandom}, 5'($urandom), ($urandom_range(0, 2) != 0));
            tick();
            n_vec++; if (fpu_cpx_vld !== (mq.size() > 0)) begin n_bad++; $display("FAIL rand_vld[%0d] got %b want %b", c, fpu_cpx_vld, (mq.size() > 0)); end
            if (mq.size() > 0) begin
                n_vec++; if (fpu_cpx_pkt !== mq[0]) begin n_bad++; $display("FAIL rand_pkt[%0d] got %h want %h", c, fpu_cpx_pkt, mq[0]); end
            end
            n_vec++; if (outq_afull !== (mq.size() >= AFULL_LVL)) begin n_bad++; $display("FAIL rand_afull[%0d] got %b want %b", c, outq_afull, (mq.size() >= AFULL_LVL)); end
            n_vec++; if (outq_err !== merr) begin n_bad++; $display("FAIL rand_err[%0d] got %b want %b", c, outq_err, merr); end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_full_push_pop();
        test_multi_hot();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
